// File: rtl/uart_tx_sched_if.sv
// Bundle between the byte requesters, the round-robin scheduler and the uart_tx.
// The scheduler takes the slave view; the requester/transmitter side takes the master view.
interface uart_tx_sched_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] data_in;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            ack;
  logic [N_REQ-1:0]            err;
  logic [DATA_WIDTH-1:0]       tx_data;
  logic                        tx_run_n;
  logic                        tx_done;
  logic                        busy;

  modport slave  (input  req, data_in, tx_done,
                  output gnt, ack, err, tx_data, tx_run_n, busy);
  modport master (output req, data_in, tx_done,
                  input  gnt, ack, err, tx_data, tx_run_n, busy);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between N_REQ byte sources.
//   state | meaning
//   IDLE  | arbitrate pending requests; grant, capture byte
//   START | drive the one-cycle active-low run strobe
//   WAIT  | wait for tx_done or the watchdog to expire
//   GAP   | hold off for GAP_CYCLES before the next grant
module uart_tx_sched #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input logic            clk,
  input logic            rst,
  uart_tx_sched_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         owner, owner_nxt;
  logic [PW-1:0]         rr_ptr, rr_nxt;
  logic [15:0]           wd_cnt, wd_nxt;
  logic [7:0]            gap_cnt, gap_nxt;
  logic [DATA_WIDTH-1:0] tx_data, data_nxt;
  logic [N_REQ-1:0]      gnt, gnt_nxt, ack, ack_nxt, err, err_nxt;
  logic                  tx_run_n, run_n_nxt;

  logic [PW-1:0]         win;
  logic                  win_vld;
  logic [PW-1:0]         owner_inc;
  int                    idx;

  // Scan from rr_ptr upward with wrap; first asserted request wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  assign owner_inc = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    wd_nxt    = wd_cnt;
    gap_nxt   = gap_cnt;
    data_nxt  = tx_data;
    gnt_nxt   = '0;
    ack_nxt   = '0;
    err_nxt   = '0;
    run_n_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt_nxt[win] = 1'b1;
          data_nxt     = bus.data_in[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          owner_nxt    = win;
          state_nxt    = START;
        end
      end
      START: begin
        run_n_nxt = 1'b0;
        wd_nxt    = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done takes precedence over a coincident watchdog expiry
        if (bus.tx_done) begin
          ack_nxt[owner] = 1'b1;
          rr_nxt         = owner_inc;
          gap_nxt        = '0;
          state_nxt      = GAP;
        end else if (wd_cnt == 16'(TIMEOUT - 1)) begin
          err_nxt[owner] = 1'b1;
          rr_nxt         = owner_inc;
          gap_nxt        = '0;
          state_nxt      = GAP;
        end else begin
          wd_nxt = wd_cnt + 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt == 8'(GAP_CYCLES - 1)) state_nxt = IDLE;
        else                               gap_nxt   = gap_cnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      wd_cnt   <= '0;
      gap_cnt  <= '0;
      tx_data  <= '0;
      gnt      <= '0;
      ack      <= '0;
      err      <= '0;
      tx_run_n <= 1'b1;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      wd_cnt   <= wd_nxt;
      gap_cnt  <= gap_nxt;
      tx_data  <= data_nxt;
      gnt      <= gnt_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      tx_run_n <= run_n_nxt;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.ack      = ack;
  assign bus.err      = err;
  assign bus.tx_data  = tx_data;
  assign bus.tx_run_n = tx_run_n;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized frames checked
// against a round-robin reference model and frame-timing expectations.
module tb_uart_tx_sched;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ptr   = 0;

  uart_tx_sched_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  uart_tx_sched #(
    .N_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: first requester at or after the priority pointer, cyclically.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    chk({tag, "_ack"},   32'(bus.ack), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_run_n"}, 32'(bus.tx_run_n), 32'd1);
    chk({tag, "_data"},  32'(bus.tx_data), 32'd0);
  endtask

  task automatic do_reset();
    bus.req     = '0;
    bus.tx_done = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr = 0;
    check_reset_state("rst");
  endtask

  // mode 0: done after lat clocks; 1: timeout; 2: done on the timeout cycle.
  // Called in an IDLE cycle; returns in the first IDLE cycle after the gap.
  task automatic run_frame(input logic [N-1:0] r, input int mode, input int lat,
                           input bit spur, input logic [N*DW-1:0] dat);
    int            w;
    logic [DW-1:0] b;
    bit            quiet;
    bus.data_in = dat;
    bus.req     = r;
    w = pick(r, ptr);
    b = dat[w*DW +: DW];
    step();
    chk("gnt",        32'(bus.gnt), 32'(1) << w);
    chk("gnt_data",   32'(bus.tx_data), 32'(b));
    chk("busy_start", 32'(bus.busy), 32'd1);
    chk("run_n_gnt",  32'(bus.tx_run_n), 32'd1);
    bus.data_in = {$urandom()};
    step();
    chk("run_n_low",  32'(bus.tx_run_n), 32'd0);
    chk("gnt_pulse",  32'(bus.gnt), 32'd0);
    if (mode == 0) begin
      step();
      chk("run_n_high", 32'(bus.tx_run_n), 32'd1);
      repeat (lat - 1) step();
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      chk("ack", 32'(bus.ack), 32'(1) << w);
      chk("no_err", 32'(bus.err), 32'd0);
    end else begin
      quiet = 1'b1;
      for (int i = 0; i < TO - 1; i++) begin
        step();
        if (bus.err !== '0 || bus.ack !== '0 || bus.tx_run_n !== 1'b1) quiet = 1'b0;
      end
      chk("wait_quiet", 32'(quiet), 32'd1);
      if (mode == 2) bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      if (mode == 2) begin
        chk("late_ack", 32'(bus.ack), 32'(1) << w);
        chk("late_no_err", 32'(bus.err), 32'd0);
      end else begin
        chk("timeout_err", 32'(bus.err), 32'(1) << w);
        chk("timeout_no_ack", 32'(bus.ack), 32'd0);
      end
    end
    chk("data_held", 32'(bus.tx_data), 32'(b));
    ptr = (w + 1) % N;
    if (spur) bus.tx_done = 1'b1;
    for (int i = 0; i < GAP - 1; i++) begin
      step();
      bus.tx_done = 1'b0;
      chk("busy_gap", 32'(bus.busy), 32'd1);
      chk("ack_gap", 32'(bus.ack), 32'd0);
    end
    step();
    bus.tx_done = 1'b0;
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("data_idle", 32'(bus.tx_data), 32'(b));
  endtask

  initial begin
    logic [N-1:0]    r;
    int              mode;
    bus.req     = '0;
    bus.data_in = '0;
    bus.tx_done = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state("init");
    step();

    // single request, byte A5 on requester 1
    run_frame(4'b0010, 0, 40, 1'b0, 32'h1234_A578);
    bus.req = '0;

    // spurious done while idle
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("spur_idle_ack",  32'(bus.ack), 32'd0);
    chk("spur_idle_busy", 32'(bus.busy), 32'd0);
    chk("spur_idle_gnt",  32'(bus.gnt), 32'd0);

    // fairness with all requesting, then wrap-around with 1001
    do_reset();
    for (int k = 0; k < 4; k++) run_frame(4'b1111, 0, $urandom_range(1, 10), 1'b1, {$urandom()});
    run_frame(4'b1001, 0, 3, 1'b0, {$urandom()});
    run_frame(4'b1001, 0, 3, 1'b0, {$urandom()});
    bus.req = '0;

    // watchdog expiry, then done coinciding with expiry
    run_frame(4'b0100, 1, 0, 1'b0, {$urandom()});
    run_frame(4'b0100, 2, 0, 1'b0, {$urandom()});
    bus.req = '0;

    // reset during WAIT, stale done afterwards
    bus.data_in = {$urandom()};
    bus.req     = 4'b0100;
    step();
    bus.req = '0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr = 0;
    check_reset_state("midwait");
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("stale_ack",  32'(bus.ack), 32'd0);
    chk("stale_busy", 32'(bus.busy), 32'd0);
    run_frame(4'b0001, 0, 12, 1'b0, {$urandom()});
    bus.req = '0;

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      r    = N'($urandom_range(1, 15));
      mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_frame(r, mode, $urandom_range(1, 45), 1'($urandom_range(0, 1)), {$urandom()});
    end
    bus.req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
